// File: rtl/noc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// noc_pkg : flit type codes and arbiter FSM encoding shared by the mesh node.
// Revision: 1.0
// ----------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_ID_RANGE = 2;

  localparam logic [FLIT_ID_RANGE-1:0] FLIT_BODY   = 2'b00;
  localparam logic [FLIT_ID_RANGE-1:0] FLIT_TAIL   = 2'b01;
  localparam logic [FLIT_ID_RANGE-1:0] FLIT_HEAD   = 2'b10;
  localparam logic [FLIT_ID_RANGE-1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic logic is_head(input logic [FLIT_ID_RANGE-1:0] fid);
    return (fid == FLIT_HEAD) || (fid == FLIT_SINGLE);
  endfunction

  function automatic logic is_tail(input logic [FLIT_ID_RANGE-1:0] fid);
    return (fid == FLIT_TAIL) || (fid == FLIT_SINGLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : rotating-priority search starting at ptr_i, wrapping modulo N.
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_gnt_o
);

  // Walk from the farthest offset down so the closest request to ptr_i wins.
  always_comb begin
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        gnt_idx_o = IDX_W'((int'(ptr_i) + k) % N);
        any_gnt_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wormhole_out_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wormhole_out_arbiter : per-output round-robin arbiter holding a lock per worm.
// Revision: 1.0
// ----------------------------------------------------------------------------
module wormhole_out_arbiter
  import noc_pkg::*;
#(
  parameter int IN_N        = 5,
  parameter int OUT_M       = 5,
  parameter int OUT_CHAN_ID = 0,
  parameter int FLIT_ID_W   = 2,
  parameter int PKT_CNT_W   = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [IN_N*$clog2(OUT_M)-1:0]  rtr_res_i,
  input  logic [IN_N-1:0]                rtr_res_vld_i,
  input  logic [IN_N*FLIT_ID_W-1:0]      flit_id_i,
  input  logic [IN_N-1:0]                data_vld_i,
  input  logic                           forward_node_rdy_i,
  output logic [$clog2(IN_N)-1:0]        sel_o,
  output logic                           out_vld_o,
  output logic [IN_N-1:0]                chan_alloc_o,
  output logic                           busy_o,
  output logic [PKT_CNT_W-1:0]           pkt_cnt_o
);

  localparam int SEL_W = $clog2(IN_N);
  localparam int RTR_W = $clog2(OUT_M);

  arb_state_e             state_q;
  logic [SEL_W-1:0]       owner_q;
  logic [SEL_W-1:0]       rr_ptr_q;
  logic [SEL_W-1:0]       rr_ptr_d;
  logic [IN_N-1:0]        chan_alloc_q;
  logic                   busy_q;
  logic [PKT_CNT_W-1:0]   pkt_cnt_q;
  logic [PKT_CNT_W-1:0]   pkt_cnt_d;

  logic [IN_N-1:0]          req_w;
  logic [SEL_W-1:0]         gnt_idx_w;
  logic                     any_gnt_w;
  logic [FLIT_ID_RANGE-1:0] own_fid_w;
  logic                     xfer_w;

  // Only worm openers aimed at this output may compete for it.
  for (genvar i = 0; i < IN_N; i++) begin : g_req
    logic [FLIT_ID_RANGE-1:0] fid;
    assign fid      = flit_id_i[i*FLIT_ID_W +: FLIT_ID_RANGE];
    assign req_w[i] = data_vld_i[i] & rtr_res_vld_i[i]
                    & (rtr_res_i[i*RTR_W +: RTR_W] == RTR_W'(OUT_CHAN_ID))
                    & is_head(fid);
  end

  rr_arbiter #(
    .N     (IN_N),
    .IDX_W (SEL_W)
  ) u_rr_arbiter (
    .req_i     (req_w),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (gnt_idx_w),
    .any_gnt_o (any_gnt_w)
  );

  assign rr_ptr_d  = (gnt_idx_w == SEL_W'(IN_N - 1)) ? '0 : gnt_idx_w + 1'b1;
  assign pkt_cnt_d = pkt_cnt_q + 1'b1;
  assign own_fid_w = flit_id_i[owner_q*FLIT_ID_W +: FLIT_ID_RANGE];
  assign xfer_w    = (state_q == ST_LOCKED) & data_vld_i[owner_q] & forward_node_rdy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      chan_alloc_q <= '0;
      busy_q       <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_gnt_w) begin
            state_q      <= ST_LOCKED;
            owner_q      <= gnt_idx_w;
            chan_alloc_q <= IN_N'(1) << gnt_idx_w;
            busy_q       <= 1'b1;
            rr_ptr_q     <= rr_ptr_d;
          end
        end
        ST_LOCKED: begin
          // A HEAD seen mid-worm is just payload; only a tail closes the lock.
          if (xfer_w && is_tail(own_fid_w)) begin
            state_q      <= ST_IDLE;
            chan_alloc_q <= '0;
            busy_q       <= 1'b0;
            pkt_cnt_q    <= pkt_cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel_o        = owner_q;
  assign out_vld_o    = xfer_w;
  assign chan_alloc_o = chan_alloc_q;
  assign busy_o       = busy_q;
  assign pkt_cnt_o    = pkt_cnt_q;

endmodule
`default_nettype wire

// File: doc/wormhole_out_arbiter.md
# wormhole_out_arbiter

Per-output-channel round-robin arbiter for the 2D-mesh wormhole node: one instance per output port sits between the input virtual channels and the crossbar. It grants the output to one input on a HEAD flit and holds the lock for the whole worm until the TAIL flit leaves. It drives the crossbar select, the output valid and the one-hot channel allocation back to the VCs, and counts forwarded packets.

## Interface
- IN_N, 5, number of input channels
- OUT_M, 5, number of output channels
- OUT_CHAN_ID, 0, index of the output channel this instance owns
- FLIT_ID_W, 2, flit type field width
- PKT_CNT_W, 8, packet counter width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; one clock, asynchronous, active-high
- rtr_res_i  in  IN_N*$clog2(OUT_M)  per-input routing result, input i at slice i
- rtr_res_vld_i  in  IN_N  routing result valid per input
- flit_id_i  in  IN_N*FLIT_ID_W  flit type at head of each input VC
- data_vld_i  in  IN_N  VC head flit valid
- forward_node_rdy_i  in  1  downstream buffer not full
- sel_o  out  $clog2(IN_N)  crossbar select (registered owner index)
- out_vld_o  out  1  flit transferred on this output this cycle
- chan_alloc_o  out  IN_N  one-hot grant to owning input, 0 when idle
- busy_o  out  1  output locked to a worm
- pkt_cnt_o  out  PKT_CNT_W  packets (tails) forwarded, wraps

## Operation
- Flit IDs: BODY=2'b00, TAIL=2'b01, HEAD=2'b10, SINGLE=2'b11 (head+tail).
- req[i] = data_vld_i[i] & rtr_res_vld_i[i] & (rtr_res_i[i]==OUT_CHAN_ID) & (flit_id_i[i] is HEAD or SINGLE).
- FSM IDLE/LOCKED.
- IDLE: chan_alloc_o=0, out_vld_o=0, busy_o=0. If any req, pick the first set req searching rr_ptr, rr_ptr+1, ... modulo IN_N; register owner into sel_o, set chan_alloc_o=1<<owner, set rr_ptr=(owner+1) mod IN_N, go LOCKED. No req: stay, sel_o holds last value.
- LOCKED: out_vld_o = data_vld_i[owner] & forward_node_rdy_i (combinational). Inputs other than owner are ignored. Transfer with flit_id TAIL or SINGLE: go IDLE, clear chan_alloc_o/busy_o, pkt_cnt_o+1 (wraps 2^PKT_CNT_W-1 -> 0).
- HEAD from owner while LOCKED is forwarded as body; the lock is not released.
- BODY/TAIL at an input in IDLE does not raise req.
- Reset (asynchronous, any time including mid-worm): state IDLE, rr_ptr=0, sel_o=0, chan_alloc_o=0, busy_o=0, out_vld_o=0, pkt_cnt_o=0.

## Timing
- Arbitration latency 1 cycle: req at cycle N in IDLE -> sel_o/chan_alloc_o/busy_o valid at N+1. First flit transfer earliest at N+1.
- Throughput inside a worm: 1 flit/cycle while owner valid and forward_node_rdy_i=1.
- Tail transferred at cycle T -> IDLE at T+1, earliest next grant visible at T+2. One bubble cycle between worms.
- forward_node_rdy_i=0: out_vld_o=0, state/owner held, no flit consumed (VC pops only on chan_alloc_o & rdy).
- Simultaneous requests: exactly one grant; the last winner gets lowest priority next time.

## Structure
- Shared package noc_pkg: flit ID constants (FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE), FLIT_ID_RANGE, FSM state encoding.
- Sub-module rr_arbiter: combinational rotating-priority search (req, ptr -> grant index, any_grant), parameterized by N.
- Top holds the FSM, owner/rr_ptr registers, out_vld logic and packet counter.

## Test plan
IN_N=5, OUT_CHAN_ID=2.
- Assert rst_i mid-cycle with clock stopped -> all outputs 0 immediately. Release -> remain 0 with no req.
- Input 3: HEAD to out 2 at cycle 1, BODY, TAIL with rdy=1 -> cycle 2 sel_o=3, chan_alloc_o=5'b01000, busy_o=1. out_vld_o=1 for 3 cycles. After tail, busy_o=0 and pkt_cnt_o=1.
- Inputs 0,1,4 hold SINGLE flits to out 2 after reset -> grant order 0,1,4, each with 1 bubble. Then input 0 again (pointer wrap). pkt_cnt_o=3 after third.
- forward_node_rdy_i=0 for 4 cycles while LOCKED with TAIL pending -> out_vld_o=0, busy_o=1 held. Release only on the cycle rdy returns.
- Input 1 HEAD routed to out 4, input 2 BODY routed to out 2 in IDLE -> no grant, chan_alloc_o=0.
- rst_i asserted during BODY of a worm from input 0 -> IDLE, pkt_cnt_o=0. New HEAD from input 4 then gets grant 4.
